// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin ownership of one shared slave, grant held
// for the whole bus cycle, with a watchdog that turns an unacknowledged strobe into a one-cycle error.
//
// state | meaning
// IDLE  | no owner, slave-side outputs parked at zero
// OWN0  | master 0 owns the slave until wbs0_cyc_i drops
// OWN1  | master 1 owns the slave until wbs1_cyc_i drops
module wb_arbiter_2m #(
   parameter int TIMEOUT  = 255,
   parameter int CNT_BITS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wbs0_cyc_i,
   input  logic        wbs0_stb_i,
   input  logic [31:0] wbs0_addr_i,
   input  logic [2:0]  wbs0_cti_i,
   input  logic [1:0]  wbs0_bte_i,
   input  logic [3:0]  wbs0_sel_i,
   input  logic        wbs0_we_i,
   input  logic [31:0] wbs0_data_i,
   output logic [31:0] wbs0_data_o,
   output logic        wbs0_ack_o,
   output logic        wbs0_err_o,
   input  logic        wbs1_cyc_i,
   input  logic        wbs1_stb_i,
   input  logic [31:0] wbs1_addr_i,
   input  logic [2:0]  wbs1_cti_i,
   input  logic [1:0]  wbs1_bte_i,
   input  logic [3:0]  wbs1_sel_i,
   input  logic        wbs1_we_i,
   input  logic [31:0] wbs1_data_i,
   output logic [31:0] wbs1_data_o,
   output logic        wbs1_ack_o,
   output logic        wbs1_err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [31:0] wbm_addr_o,
   output logic [2:0]  wbm_cti_o,
   output logic [1:0]  wbm_bte_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_data_o,
   input  logic [31:0] wbm_data_i,
   input  logic        wbm_ack_i,
   output logic [1:0]  grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   // Terminal count of the watchdog; irrelevant when TIMEOUT is 0 since err_set is then gated off.
   localparam logic [CNT_BITS-1:0] CNT_TC = CNT_BITS'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t              state;
   state_t              state_nxt;
   logic                last;
   logic                err_pending;
   logic                err_set;
   logic [CNT_BITS-1:0] cnt;
   logic                own0;
   logic                own1;
   logic                owner_cyc;
   logic                owner_stb;

   assign own0 = (state == OWN0);
   assign own1 = (state == OWN1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state_nxt == OWN0 && state != OWN0) begin
            last <= 1'b0;
         end else if (state_nxt == OWN1 && state != OWN1) begin
            last <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (wbs0_cyc_i && wbs1_cyc_i) begin
               state_nxt = last ? OWN0 : OWN1;
            end else if (wbs0_cyc_i) begin
               state_nxt = OWN0;
            end else if (wbs1_cyc_i) begin
               state_nxt = OWN1;
            end
         end
         OWN0: begin
            if (!wbs0_cyc_i) begin
               state_nxt = wbs1_cyc_i ? OWN1 : IDLE;
            end
         end
         OWN1: begin
            if (!wbs1_cyc_i) begin
               state_nxt = wbs0_cyc_i ? OWN0 : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      owner_cyc  = 1'b0;
      owner_stb  = 1'b0;
      wbm_we_o   = 1'b0;
      wbm_addr_o = '0;
      wbm_cti_o  = '0;
      wbm_bte_o  = '0;
      wbm_sel_o  = '0;
      wbm_data_o = '0;
      if (own0) begin
         owner_cyc  = wbs0_cyc_i;
         owner_stb  = wbs0_stb_i;
         wbm_we_o   = wbs0_we_i;
         wbm_addr_o = wbs0_addr_i;
         wbm_cti_o  = wbs0_cti_i;
         wbm_bte_o  = wbs0_bte_i;
         wbm_sel_o  = wbs0_sel_i;
         wbm_data_o = wbs0_data_i;
      end else if (own1) begin
         owner_cyc  = wbs1_cyc_i;
         owner_stb  = wbs1_stb_i;
         wbm_we_o   = wbs1_we_i;
         wbm_addr_o = wbs1_addr_i;
         wbm_cti_o  = wbs1_cti_i;
         wbm_bte_o  = wbs1_bte_i;
         wbm_sel_o  = wbs1_sel_i;
         wbm_data_o = wbs1_data_i;
      end
   end

   // Only raise an error toward a master that is still holding cyc, so it cannot leak to the next owner.
   assign err_set = (TIMEOUT != 0) && owner_cyc && owner_stb && !wbm_ack_i
                    && !err_pending && (cnt == CNT_TC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         err_pending <= 1'b0;
      end else begin
         err_pending <= err_set;
         if (!owner_stb || wbm_ack_i || err_pending) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_BITS'(1);
         end
      end
   end

   assign wbm_cyc_o   = owner_cyc;
   assign wbm_stb_o   = owner_stb & ~err_pending;
   assign wbs0_ack_o  = wbm_ack_i & own0 & ~err_pending;
   assign wbs1_ack_o  = wbm_ack_i & own1 & ~err_pending;
   assign wbs0_err_o  = err_pending & own0;
   assign wbs1_err_o  = err_pending & own1;
   assign wbs0_data_o = wbm_data_i;
   assign wbs1_data_o = wbm_data_i;
   assign grant       = {own1, own0};

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed scenarios plus randomized traffic, every cycle compared
// against an ownership/watchdog model kept in plain integers.
module tb_wb_arbiter_2m;

   localparam int TIMEOUT = 8;

   logic        clk;
   logic        rst_n;
   logic        cyc [2];
   logic        stb [2];
   logic        we  [2];
   logic [31:0] addr[2];
   logic [31:0] wdat[2];
   logic [2:0]  cti [2];
   logic [1:0]  bte [2];
   logic [3:0]  sel [2];
   logic [31:0] rdat;
   logic        ack_in;

   logic [31:0] wbs0_data_o, wbs1_data_o;
   logic        wbs0_ack_o, wbs1_ack_o, wbs0_err_o, wbs1_err_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [31:0] wbm_addr_o, wbm_data_o;
   logic [2:0]  wbm_cti_o;
   logic [1:0]  wbm_bte_o;
   logic [3:0]  wbm_sel_o;
   logic [1:0]  grant;

   int n_err = 0;
   int n_chk = 0;

   // Model: owner is -1 when idle, wait_c counts strobe cycles without ack.
   int owner;
   int last_m;
   int wait_c;
   bit m_err;

   wb_arbiter_2m #(.TIMEOUT(TIMEOUT), .CNT_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .wbs0_cyc_i(cyc[0]), .wbs0_stb_i(stb[0]), .wbs0_addr_i(addr[0]), .wbs0_cti_i(cti[0]),
      .wbs0_bte_i(bte[0]), .wbs0_sel_i(sel[0]), .wbs0_we_i(we[0]), .wbs0_data_i(wdat[0]),
      .wbs0_data_o(wbs0_data_o), .wbs0_ack_o(wbs0_ack_o), .wbs0_err_o(wbs0_err_o),
      .wbs1_cyc_i(cyc[1]), .wbs1_stb_i(stb[1]), .wbs1_addr_i(addr[1]), .wbs1_cti_i(cti[1]),
      .wbs1_bte_i(bte[1]), .wbs1_sel_i(sel[1]), .wbs1_we_i(we[1]), .wbs1_data_i(wdat[1]),
      .wbs1_data_o(wbs1_data_o), .wbs1_ack_o(wbs1_ack_o), .wbs1_err_o(wbs1_err_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_addr_o(wbm_addr_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
      .wbm_sel_o(wbm_sel_o), .wbm_data_o(wbm_data_o),
      .wbm_data_i(rdat), .wbm_ack_i(ack_in), .grant(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      owner  = -1;
      last_m = 1;
      wait_c = 0;
      m_err  = 1'b0;
   endtask

   task automatic model_step();
      int nxt;
      bit nerr;
      if (!rst_n) begin
         model_reset();
         return;
      end
      nerr = 1'b0;
      if (owner >= 0) begin
         if (cyc[owner] && stb[owner] && !ack_in && !m_err && wait_c == TIMEOUT - 1)
            nerr = 1'b1;
      end
      if (owner < 0) wait_c = 0;
      else if (!stb[owner] || ack_in || m_err) wait_c = 0;
      else wait_c++;
      nxt = owner;
      if (owner < 0) begin
         if (cyc[0] && cyc[1]) nxt = (last_m == 1) ? 0 : 1;
         else if (cyc[0]) nxt = 0;
         else if (cyc[1]) nxt = 1;
      end else if (!cyc[owner]) begin
         nxt = cyc[1 - owner] ? 1 - owner : -1;
      end
      if (nxt >= 0 && nxt != owner) last_m = nxt;
      owner = nxt;
      m_err = nerr;
   endtask

   task automatic check_model();
      logic [1:0]  eg, ea, ee;
      logic        ec, es;
      logic [73:0] eb;
      eg = '0; ea = '0; ee = '0; ec = 1'b0; es = 1'b0; eb = '0;
      if (owner >= 0) begin
         eg[owner] = 1'b1;
         ec        = cyc[owner];
         es        = stb[owner] & ~m_err;
         eb        = {addr[owner], wdat[owner], sel[owner], cti[owner], bte[owner], we[owner]};
         ea[owner] = ack_in & ~m_err;
         ee[owner] = m_err;
      end
      chk("grant", grant, eg);
      chk("wbm_cyc", wbm_cyc_o, ec);
      chk("wbm_stb", wbm_stb_o, es);
      chk("wbm_bus", {wbm_addr_o, wbm_data_o, wbm_sel_o, wbm_cti_o, wbm_bte_o, wbm_we_o}, eb);
      chk("ack", {wbs1_ack_o, wbs0_ack_o}, ea);
      chk("err", {wbs1_err_o, wbs0_err_o}, ee);
      chk("rdata", {wbs1_data_o, wbs0_data_o}, {rdat, rdat});
   endtask

   task automatic settle();
      @(negedge clk);
      check_model();
   endtask

   task automatic adv();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic step();
      settle();
      adv();
   endtask

   task automatic clear_inputs();
      for (int n = 0; n < 2; n++) begin
         cyc[n] = 1'b0; stb[n] = 1'b0; we[n] = 1'b0; addr[n] = '0;
         wdat[n] = '0; cti[n] = '0; bte[n] = '0; sel[n] = '0;
      end
      ack_in = 1'b0;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      rdat = 32'hA5A5_5A5A;
      model_reset();
      #2;
      chk("rst_grant", grant, 2'b00);
      chk("rst_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 2'b00);
      chk("rst_bus", {wbm_addr_o, wbm_data_o, wbm_sel_o, wbm_cti_o, wbm_bte_o, wbm_we_o}, 74'd0);
      chk("rst_ack_err", {wbs1_ack_o, wbs0_ack_o, wbs1_err_o, wbs0_err_o}, 4'b0000);
      chk("rst_rdata", wbs0_data_o, 32'hA5A5_5A5A);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single read from master 0
      apply_reset();
      cyc[0] = 1'b1; stb[0] = 1'b1; addr[0] = 32'h40; sel[0] = 4'hF;
      step();
      ack_in = 1'b1; rdat = 32'h1234_5678;
      settle();
      chk("t1_grant", grant, 2'b01);
      chk("t1_addr", wbm_addr_o, 32'h40);
      chk("t1_ack0", wbs0_ack_o, 1'b1);
      chk("t1_data0", wbs0_data_o, 32'h1234_5678);
      chk("t1_ack1", wbs1_ack_o, 1'b0);
      adv();
      ack_in = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
      step();

      // Simultaneous requests, zero-gap handover, second tie
      apply_reset();
      cyc[0] = 1'b1; stb[0] = 1'b1; addr[0] = 32'h44;
      cyc[1] = 1'b1; stb[1] = 1'b1; addr[1] = 32'h80;
      step();
      settle();
      chk("t2_first", grant, 2'b01);
      adv();
      cyc[0] = 1'b0; stb[0] = 1'b0;
      step();
      settle();
      chk("t2_handover", grant, 2'b10);
      chk("t2_addr1", wbm_addr_o, 32'h80);
      adv();
      cyc[1] = 1'b0; stb[1] = 1'b0;
      step();
      settle();
      chk("t2_idle", grant, 2'b00);
      adv();
      cyc[0] = 1'b1; stb[0] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
      step();
      settle();
      chk("t2_tie2", grant, 2'b01);
      adv();
      cyc[0] = 1'b0; stb[0] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0;
      step();

      // Four-beat burst from master 1 while master 0 waits
      cyc[1] = 1'b1; stb[1] = 1'b1; cti[1] = 3'b010; sel[1] = 4'hF; we[1] = 1'b1;
      wdat[1] = 32'hCAFE_0000;
      cyc[0] = 1'b1; stb[0] = 1'b1; addr[0] = 32'h200;
      step();
      for (int b = 0; b < 4; b++) begin
         ack_in = 1'b1; addr[1] = 32'h100 + 32'(4 * b); wdat[1] = 32'hCAFE_0000 + 32'(b);
         if (b == 3) cti[1] = 3'b111;
         settle();
         chk("t3_grant", grant, 2'b10);
         chk("t3_ack1", wbs1_ack_o, 1'b1);
         chk("t3_ack0", wbs0_ack_o, 1'b0);
         adv();
      end
      ack_in = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; cti[1] = 3'b000; we[1] = 1'b0;
      settle();
      chk("t3_hold", grant, 2'b10);
      adv();
      settle();
      chk("t3_m0_after", grant, 2'b01);
      adv();
      ack_in = 1'b1;
      step();
      ack_in = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
      step();

      // Watchdog: slave never acks, master keeps strobing
      cyc[0] = 1'b1; stb[0] = 1'b1; addr[0] = 32'h300;
      step();
      for (int i = 0; i < 18; i++) begin
         settle();
         chk("wd_err0", wbs0_err_o, (i == 8 || i == 17) ? 1'b1 : 1'b0);
         chk("wd_stb", wbm_stb_o, (i == 8 || i == 17) ? 1'b0 : 1'b1);
         chk("wd_err1", wbs1_err_o, 1'b0);
         adv();
      end
      cyc[0] = 1'b0; stb[0] = 1'b0;
      step();

      // Async reset in the middle of a master 1 burst
      cyc[1] = 1'b1; stb[1] = 1'b1; cti[1] = 3'b010; addr[1] = 32'h400; sel[1] = 4'hF;
      cyc[0] = 1'b1; stb[0] = 1'b1; addr[0] = 32'h500;
      step();
      ack_in = 1'b1;
      settle();
      chk("t5_m1_owns", grant, 2'b10);
      adv();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t5_grant", grant, 2'b00);
      chk("t5_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 2'b00);
      chk("t5_bus", {wbm_addr_o, wbm_data_o, wbm_sel_o, wbm_cti_o, wbm_bte_o, wbm_we_o}, 74'd0);
      chk("t5_ack", {wbs1_ack_o, wbs0_ack_o}, 2'b00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ack_in = 1'b0;
      step();
      settle();
      chk("t5_m0_wins", grant, 2'b01);
      adv();
      clear_inputs();
      step();
      step();

      // Randomized traffic with periodic ack-free stretches to provoke the watchdog
      for (int i = 0; i < 800; i++) begin
         for (int n = 0; n < 2; n++) begin
            if ($urandom_range(0, 7) == 0) cyc[n] = ~cyc[n];
            stb[n]  = cyc[n] & ($urandom_range(0, 3) != 0);
            addr[n] = $urandom;
            wdat[n] = $urandom;
            sel[n]  = 4'($urandom);
            cti[n]  = 3'($urandom);
            bte[n]  = 2'($urandom);
            we[n]   = 1'($urandom);
         end
         rdat   = $urandom;
         ack_in = ((i % 100) < 25) ? 1'b0 : ($urandom_range(0, 2) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master Wishbone arbiter that shares one slave, typically the SRAM controller, between two bus masters such as the CPU data port and a DMA/VGA fetch unit. It grants the slave to one master at a time, holds the grant for the whole bus cycle including bursts, and alternates priority round-robin. A watchdog counter terminates any access the slave never acknowledges by returning a one-cycle error to the owning master.

## Interface
- TIMEOUT, 255: cycles a granted strobe may wait for ack before error; 0 disables watchdog.
- CNT_BITS, 8: width of watchdog counter; must hold TIMEOUT.
- clk  in  1  bus clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wbs0_cyc_i / wbs1_cyc_i  in  1  master n cycle request.
- wbs0_stb_i / wbs1_stb_i  in  1  master n strobe.
- wbs0_addr_i / wbs1_addr_i  in  32  master n address.
- wbs0_cti_i / wbs1_cti_i  in  3  master n cycle type.
- wbs0_bte_i / wbs1_bte_i  in  2  master n burst type.
- wbs0_sel_i / wbs1_sel_i  in  4  master n byte select.
- wbs0_we_i / wbs1_we_i  in  1  master n write enable.
- wbs0_data_i / wbs1_data_i  in  32  master n write data.
- wbs0_data_o / wbs1_data_o  out  32  read data, both driven from wbm_data_i.
- wbs0_ack_o / wbs1_ack_o  out  1  ack to master n.
- wbs0_err_o / wbs1_err_o  out  1  watchdog error to master n.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  to slave.
- wbm_addr_o  out  32; wbm_cti_o  out  3; wbm_bte_o  out  2; wbm_sel_o  out  4; wbm_data_o  out  32: to slave.
- wbm_data_i  in  32; wbm_ack_i  in  1: from slave.
- grant  out  2  one-hot current owner, 00 when idle.

## Operation
- States: IDLE, OWN0, OWN1. Registered `last` bit records the most recently granted master. The reset value of `last` is 1, so master 0 wins the first tie.
- IDLE: if only one cyc_i is high, go to that master's OWN state. If both are high, go to the OWN state of the master that is not `last`. If neither is high, stay in IDLE.
- OWNn: the grant is held while wbsn_cyc_i=1. When wbsn_cyc_i=0 at a clock edge:
  - if the other master's cyc_i=1, go directly to OWN(other);
  - otherwise go to IDLE.
- `last` updates on every entry into an OWN state.
- The other master's requests are ignored while OWNn is active. No preemption.
- Slave-side mux, combinational from the registered state:
  - In OWNn, all wbm_*_o except cyc/stb copy master n's inputs.
  - wbm_cyc_o = wbsn_cyc_i.
  - wbm_stb_o = wbsn_stb_i & ~err_pending.
  - In IDLE, wbm_cyc_o = wbm_stb_o = 0, and addr/data/sel/cti/bte/we are 0.
- Ack routing: wbsn_ack_o = wbm_ack_i & OWNn. The non-owner's ack is always 0.
- Watchdog counter `cnt`:
  - Clears when not in an OWN state, when the owner's stb is low, or when wbm_ack_i=1.
  - Otherwise increments.
  - When TIMEOUT≠0 and cnt reaches TIMEOUT-1 with no ack, the registered err_pending is set for the next cycle. During that cycle the owner's err_o=1, wbm_stb_o is forced 0 and cnt clears.
  - err_pending self-clears after one cycle.
  - ack and err are never asserted together. If wbm_ack_i arrives in the err cycle, it is suppressed from the master.

## Timing
- Reset, asynchronous, applied anywhere:
  - state=IDLE, last=1, cnt=0, err_pending=0.
  - grant=00, all wbm_* outputs 0, all ack/err 0, data_o = wbm_data_i.
  - An in-flight slave cycle is abandoned; cyc drops with reset.
- Arbitration latency: cyc_i rising at edge k from IDLE gives grant and wbm_cyc_o at cycle k+1.
- Handover with zero idle cycles: the owner drops cyc at edge k, the other master owns at cycle k+1.
- Ack/data path to the master is combinational: zero added latency after grant.
- Burst (cti=010): the grant persists across all beats until cyc drops. The watchdog restarts on each ack.
- Error timing: the err_o pulse comes exactly TIMEOUT cycles after stb was first seen high without ack.

## Test plan
- Reset then single request: m0 raises cyc/stb for a read of addr 0x40. Check grant=01 on the next cycle and wbm_addr_o=0x40. The slave acks with 0x12345678 → wbs0_ack_o=1, wbs0_data_o=0x12345678, wbs1_ack_o=0.
- Simultaneous requests after reset: m0 is granted first (grant=01). m0 drops cyc → grant=10 the next cycle with no IDLE gap. A second tie → m0 wins again, since last=1.
- 4-beat burst from m1 (cti=010, sel=1111) while m0 requests: grant stays 10 for all 4 acks. m0 gets grant only after m1's cyc drops.
- Watchdog: TIMEOUT=8, slave never acks. Check wbs0_err_o=1 for exactly one cycle, 8 cycles after stb, with wbm_stb_o=0 that cycle. Check cnt restarts if the master keeps stb.
- Async reset asserted mid-burst with m1 owning: all wbm outputs and grant go to 0 immediately without a clock. After release, a pending m0 request wins.
